age_order_sched: RTL and testbench

//  N-requester oldest-first scheduler in front of one shared downstream port.

---
 rtl/age_order_sched_pkg.sv | 29 ++
 rtl/age_order_sched_choose.sv | 32 +++
 rtl/age_order_sched.sv | 137 +++++++++++++
 tb/tb_age_order_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/age_order_sched_pkg.sv
// Shared types and helpers for the oldest-first scheduler.
// Widths here are the default configuration; the top re-derives widths from its parameters.
package age_order_sched_pkg;

    localparam int unsigned MAX_N      = 16;
    localparam int unsigned AGE_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [AGE_W_DEF-1:0]      age_t;
    typedef logic [$clog2(MAX_N)-1:0]  idx_t;

    typedef struct packed {
        logic                  vld;
        age_t                  age;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

    // Number of arrivals this cycle at indices below idx (prefix popcount).
    function automatic int unsigned rank_of_arrival(input logic [MAX_N-1:0] arr,
                                                    input int unsigned      idx);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned j = 0; j < MAX_N; j++) begin
            if (j < idx && arr[j]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/age_order_sched_choose.sv
// N-way combinational oldest-select: one-hot pick of the valid entry with the smallest age.
// Ties resolve to the lower index.
module choose_one_with_age_n #(
    parameter int N     = 3,
    parameter int AGE_W = 5
) (
    input  logic [N-1:0]       in_vld,
    input  logic [N*AGE_W-1:0] in_age,
    output logic [N-1:0]       out_vld
);

    logic             found;
    logic [AGE_W-1:0] best_age;
    int unsigned      best_i;

    always_comb begin
        out_vld  = '0;
        found    = 1'b0;
        best_age = '0;
        best_i   = 0;
        // Strict less-than keeps the first (lowest-index) candidate on equal ages.
        for (int unsigned i = 0; i < N; i++) begin
            if (in_vld[i] && (!found || in_age[i*AGE_W +: AGE_W] < best_age)) begin
                found    = 1'b1;
                best_age = in_age[i*AGE_W +: AGE_W];
                best_i   = i;
            end
        end
        if (found) out_vld = N'(1) << best_i;
    end

endmodule

// File: rtl/age_order_sched.sv
// Oldest-first scheduler: one pending slot per requester, issued in arrival-rank order.
// Optional same-cycle bypass into an empty scheduler: AGE_ORDER_SCHED_BYPASS_EN.
module age_order_sched
    import age_order_sched_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 32,
    parameter int AGE_W  = AGE_W_DEF,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        in_vld,
    output logic [N-1:0]        in_rdy,
    input  logic [N*DATA_W-1:0] in_data,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [IDX_W-1:0]    out_idx,
    output logic [DATA_W-1:0]   out_data,
    output logic [AGE_W-1:0]    out_age,
    output logic [IDX_W:0]      occ
);

    logic [N-1:0]        slot_vld;
    logic [AGE_W-1:0]    slot_age  [N];
    logic [DATA_W-1:0]   slot_data [N];

    logic [N*AGE_W-1:0]  age_flat;
    logic [N-1:0]        sel;
    logic [N-1:0]        grant;
    logic [N-1:0]        acc;
    logic [MAX_N-1:0]    acc_ext;
    logic [IDX_W-1:0]    sel_idx;
    logic [AGE_W-1:0]    sel_age;
    logic [DATA_W-1:0]   sel_data;
    logic [IDX_W:0]      occ_after;
    logic [AGE_W-1:0]    new_age [N];
    logic                bypass;

    always_comb begin
        age_flat = '0;
        for (int unsigned i = 0; i < N; i++) age_flat[i*AGE_W +: AGE_W] = slot_age[i];
    end

    choose_one_with_age_n #(
        .N     (N),
        .AGE_W (AGE_W)
    ) u_choose (
        .in_vld  (slot_vld),
        .in_age  (age_flat),
        .out_vld (sel)
    );

    always_comb begin
        sel_idx  = '0;
        sel_age  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel[i]) begin
                sel_idx  = IDX_W'(i);
                sel_age  = slot_age[i];
                sel_data = slot_data[i];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < N; i++) occ = occ + (IDX_W+1)'(slot_vld[i]);
    end

    assign in_rdy = ~slot_vld;
    assign grant  = sel & {N{out_rdy}};

`ifdef AGE_ORDER_SCHED_BYPASS_EN
    logic [IDX_W-1:0] byp_idx;

    always_comb begin
        bypass  = (slot_vld == '0) && $onehot(in_vld) && out_rdy;
        byp_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_vld[i]) byp_idx = IDX_W'(i);
        end
    end
`else
    assign bypass = 1'b0;
`endif

    // Stamping happens after removal: new ranks start at the post-grant occupancy.
    always_comb begin
        acc       = bypass ? '0 : (in_vld & ~slot_vld);
        acc_ext   = MAX_N'(acc);
        occ_after = occ - (IDX_W+1)'(|grant);
        for (int unsigned i = 0; i < N; i++) begin
            new_age[i] = AGE_W'(occ_after) + AGE_W'(rank_of_arrival(acc_ext, i));
        end
    end

    always_comb begin
        out_vld  = |slot_vld;
        out_idx  = sel_idx;
        out_data = sel_data;
        out_age  = sel_age;
`ifdef AGE_ORDER_SCHED_BYPASS_EN
        if (bypass) begin
            out_vld  = 1'b1;
            out_idx  = byp_idx;
            out_data = in_data[byp_idx*DATA_W +: DATA_W];
            out_age  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                slot_age[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (grant[i]) begin
                    slot_vld[i] <= 1'b0;
                    slot_age[i] <= '0;
                end else if (slot_vld[i]) begin
                    if (|grant && slot_age[i] > sel_age) slot_age[i] <= slot_age[i] - AGE_W'(1);
                end else if (acc[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_age[i]  <= new_age[i];
                    slot_data[i] <= in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_age_order_sched.sv
// Bench for age_order_sched: directed scenarios then random traffic, checked against
// an arrival-order queue model (queue position = age).
module tb_age_order_sched;

    localparam int N      = 3;
    localparam int DATA_W = 32;
    localparam int AGE_W  = 5;
    localparam int IDX_W  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        in_vld;
    logic [N-1:0]        in_rdy;
    logic [N*DATA_W-1:0] in_data;
    logic                out_vld;
    logic                out_rdy;
    logic [IDX_W-1:0]    out_idx;
    logic [DATA_W-1:0]   out_data;
    logic [AGE_W-1:0]    out_age;
    logic [IDX_W:0]      occ;

    int checks   = 0;
    int failures = 0;

    int          q[$];
    logic [31:0] mdata [N];

    always #5 clk = ~clk;

    age_order_sched #(
        .N      (N),
        .DATA_W (DATA_W),
        .AGE_W  (AGE_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_idx  (out_idx),
        .out_data (out_data),
        .out_age  (out_age),
        .occ      (occ)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_queue(input int idx);
        foreach (q[k]) if (q[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic cycle(input logic [N-1:0] v, input logic r);
        bit           byp;
        int           byp_i;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        in_vld  = v;
        out_rdy = r;
        for (int i = 0; i < N; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
        #1;
        byp   = 1'b0;
        byp_i = 0;
        for (int i = 0; i < N; i++) if (v[i]) byp_i = i;
`ifdef AGE_ORDER_SCHED_BYPASS_EN
        byp = (q.size() == 0) && $onehot(v) && r;
`endif
        for (int i = 0; i < N; i++) exp_rdy[i] = !in_queue(i);
        check("in_rdy", in_rdy, exp_rdy);
        check("occ", occ, q.size());
        if (byp) begin
            check("byp_vld", out_vld, 1);
            check("byp_idx", out_idx, byp_i);
            check("byp_data", out_data, in_data[byp_i*DATA_W +: DATA_W]);
            check("byp_age", out_age, 0);
        end else if (q.size() > 0) begin
            check("out_vld", out_vld, 1);
            check("out_idx", out_idx, q[0]);
            check("out_data", out_data, mdata[q[0]]);
            check("out_age", out_age, 0);
        end else begin
            check("out_vld_empty", out_vld, 0);
            check("out_idx_empty", out_idx, 0);
            check("out_data_empty", out_data, 0);
        end
        foreach (q[k]) check("slot_age", dut.slot_age[q[k]], k);
        if (!byp && q.size() > 0 && r) void'(q.pop_front());
        if (!byp) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    q.push_back(i);
                    mdata[i] = in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = '0;
        out_rdy = 1'b0;
        in_data = '0;
        #12;
        check("rst_out_vld", out_vld, 0);
        check("rst_occ", occ, 0);
        check("rst_in_rdy", in_rdy, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;

        // Staggered arrivals issue in arrival order 0,2,1.
        cycle(3'b001, 1'b0);
        cycle(3'b100, 1'b0);
        cycle(3'b010, 1'b0);
        cycle(3'b000, 1'b1); check("t1_first", out_idx, 0);
        cycle(3'b000, 1'b1); check("t1_second", out_idx, 2);
        cycle(3'b000, 1'b1); check("t1_third", out_idx, 1);
        cycle(3'b000, 1'b0); check("t1_empty", out_vld, 0);

        // Same-cycle arrivals: lower index is older; output holds while stalled.
        cycle(3'b111, 1'b0);
        cycle(3'b000, 1'b0);
        check("t2_in_rdy", in_rdy, 3'b000);
        check("t2_occ", occ, 3);
        check("t2_age0", dut.slot_age[0], 0);
        check("t2_age1", dut.slot_age[1], 1);
        check("t2_age2", dut.slot_age[2], 2);
        cycle(3'b101, 1'b0); check("t2_hold", out_idx, 0);

        // Full: grant idx0, then idx0 re-enters as youngest.
        cycle(3'b000, 1'b1); check("t3_grant", out_idx, 0);
        cycle(3'b001, 1'b0);
        cycle(3'b000, 1'b0);
        check("t3_age1", dut.slot_age[1], 0);
        check("t3_age2", dut.slot_age[2], 1);
        check("t3_age0", dut.slot_age[0], 2);
        cycle(3'b000, 1'b1); check("t3_issue1", out_idx, 1);

        // Grant idx2 while idx1 arrives: occ stays 2, new tag 1.
        cycle(3'b010, 1'b1); check("t4_issue2", out_idx, 2);
        cycle(3'b000, 1'b0);
        check("t4_new_age", dut.slot_age[1], 1);
        check("t4_occ", occ, 2);
        check("t4_next", out_idx, 0);

        // Mid-stall reset clears everything immediately.
        cycle(3'b111, 1'b0);
        cycle(3'b000, 1'b0);
        check("t5_full", occ, 3);
        @(negedge clk);
        out_rdy = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("t5_out_vld", out_vld, 0);
        check("t5_occ", occ, 0);
        check("t5_in_rdy", in_rdy, 3'b111);
        q.delete();
        out_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single arrival into an empty scheduler with downstream ready.
        cycle(3'b010, 1'b1);
`ifdef AGE_ORDER_SCHED_BYPASS_EN
        check("t6_byp_vld", out_vld, 1);
        check("t6_byp_idx", out_idx, 1);
        check("t6_byp_occ", occ, 0);
        cycle(3'b000, 1'b0); check("t6_after", out_vld, 0);
`else
        check("t6_same_cycle", out_vld, 0);
        cycle(3'b000, 1'b0);
        check("t6_next_vld", out_vld, 1);
        check("t6_next_idx", out_idx, 1);
`endif
        cycle(3'b000, 1'b1);

        for (int n = 0; n < 400; n++) begin
            cycle(N'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
